// File: rtl/load_store_unit.sv
// RV32I MEM stage: alignment check, byte-lane steering, single-outstanding
// data-memory handshake and load-data extension for writeback.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_load_data,
    output logic        wb_misaligned,
    output logic [31:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned MASK_W   = 4;
    localparam int unsigned FUNCT3_W = 3;

    localparam logic [FUNCT3_W-1:0] F3_B  = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_H  = 3'b001;
    localparam logic [FUNCT3_W-1:0] F3_W  = 3'b010;
    localparam logic [FUNCT3_W-1:0] F3_BU = 3'b100;
    localparam logic [FUNCT3_W-1:0] F3_HU = 3'b101;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state, state_nxt;
    logic [FUNCT3_W-1:0] f3_q, f3_nxt;
    logic [1:0]          off_q, off_nxt;
    logic [REG_W-1:0]    rd_q, rd_nxt;

    logic [XLEN-1:0]     dmem_address_nxt, dmem_wdata_nxt, wb_load_data_nxt;
    logic [MASK_W-1:0]   dmem_wmask_nxt;
    logic                dmem_read_nxt, dmem_write_nxt;
    logic                wb_valid_nxt, wb_misaligned_nxt;
    logic [REG_W-1:0]    wb_rd_nxt;

    logic                is_store, is_load, legal, aligned;
    logic [MASK_W-1:0]   st_mask;
    logic [XLEN-1:0]     st_wdata, lane, load_fmt;

    // Decode legality/alignment and build store lanes from the execute payload.
    always_comb begin
        is_store = ex_mem_write;
        is_load  = ex_mem_read & ~ex_mem_write;
        legal    = 1'b0;
        aligned  = 1'b1;
        st_mask  = '0;
        st_wdata = '0;
        case (ex_funct3)
            F3_B: begin
                legal    = 1'b1;
                st_mask  = MASK_W'(4'b0001 << ex_addr[1:0]);
                st_wdata = {4{ex_store_data[7:0]}};
            end
            F3_H: begin
                legal    = 1'b1;
                aligned  = ~ex_addr[0];
                st_mask  = MASK_W'(4'b0011 << ex_addr[1:0]);
                st_wdata = {2{ex_store_data[15:0]}};
            end
            F3_W: begin
                legal    = 1'b1;
                aligned  = (ex_addr[1:0] == 2'b00);
                st_mask  = 4'b1111;
                st_wdata = ex_store_data;
            end
            F3_BU: legal = is_load;
            F3_HU: begin
                legal   = is_load;
                aligned = ~ex_addr[0];
            end
            default: legal = 1'b0;
        endcase
    end

    // Extract and extend the addressed lane of the returned word.
    always_comb begin
        lane = dmem_rdata >> {off_q, 3'b000};
        case (f3_q)
            F3_B:    load_fmt = {{24{lane[7]}}, lane[7:0]};
            F3_H:    load_fmt = {{16{lane[15]}}, lane[15:0]};
            F3_W:    load_fmt = dmem_rdata;
            F3_BU:   load_fmt = {24'd0, lane[7:0]};
            F3_HU:   load_fmt = {16'd0, lane[15:0]};
            default: load_fmt = '0;
        endcase
    end

    // Next-state and registered-output values; everything holds by default.
    always_comb begin
        state_nxt         = state;
        f3_nxt            = f3_q;
        off_nxt           = off_q;
        rd_nxt            = rd_q;
        dmem_address_nxt  = dmem_address;
        dmem_read_nxt     = dmem_read;
        dmem_write_nxt    = dmem_write;
        dmem_wmask_nxt    = dmem_wmask;
        dmem_wdata_nxt    = dmem_wdata;
        wb_valid_nxt      = 1'b0;
        wb_rd_nxt         = wb_rd;
        wb_load_data_nxt  = wb_load_data;
        wb_misaligned_nxt = wb_misaligned;
        mem_stall         = 1'b0;
        case (state)
            IDLE: begin
                if (ex_valid) begin
                    if ((is_load | is_store) && legal && aligned) begin
                        state_nxt        = ACCESS;
                        mem_stall        = 1'b1;
                        f3_nxt           = ex_funct3;
                        off_nxt          = ex_addr[1:0];
                        rd_nxt           = ex_rd;
                        dmem_address_nxt = {ex_addr[31:2], 2'b00};
                        dmem_read_nxt    = is_load;
                        dmem_write_nxt   = is_store;
                        dmem_wmask_nxt   = is_store ? st_mask : '0;
                        dmem_wdata_nxt   = is_store ? st_wdata : '0;
                    end else begin
                        wb_valid_nxt      = 1'b1;
                        wb_rd_nxt         = ex_rd;
                        wb_load_data_nxt  = '0;
                        wb_misaligned_nxt = is_load | is_store;
                    end
                end
            end
            ACCESS: begin
                if (dmem_resp) begin
                    state_nxt         = IDLE;
                    dmem_read_nxt     = 1'b0;
                    dmem_write_nxt    = 1'b0;
                    wb_valid_nxt      = 1'b1;
                    wb_rd_nxt         = rd_q;
                    wb_load_data_nxt  = dmem_read ? load_fmt : '0;
                    wb_misaligned_nxt = 1'b0;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            f3_q          <= '0;
            off_q         <= '0;
            rd_q          <= '0;
            dmem_address  <= '0;
            dmem_read     <= 1'b0;
            dmem_write    <= 1'b0;
            dmem_wmask    <= '0;
            dmem_wdata    <= '0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_load_data  <= '0;
            wb_misaligned <= 1'b0;
        end else begin
            state         <= state_nxt;
            f3_q          <= f3_nxt;
            off_q         <= off_nxt;
            rd_q          <= rd_nxt;
            dmem_address  <= dmem_address_nxt;
            dmem_read     <= dmem_read_nxt;
            dmem_write    <= dmem_write_nxt;
            dmem_wmask    <= dmem_wmask_nxt;
            dmem_wdata    <= dmem_wdata_nxt;
            wb_valid      <= wb_valid_nxt;
            wb_rd         <= wb_rd_nxt;
            wb_load_data  <= wb_load_data_nxt;
            wb_misaligned <= wb_misaligned_nxt;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit: handshake timing, lane steering,
// extension, faults, back-to-back accesses and reset during an access.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_store_data;
    logic [4:0]  ex_rd;
    logic        mem_stall, wb_valid, wb_misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_load_data, dmem_address, dmem_wdata, dmem_rdata;
    logic        dmem_read, dmem_write, dmem_resp;
    logic [3:0]  dmem_wmask;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_load_data(wb_load_data), .wb_misaligned(wb_misaligned),
        .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_resp(dmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_ex();
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
    endtask

    // Caller sits at a negedge (cycle T); returns at the negedge after the resp cycle.
    task automatic mem_op(input string tag, input logic rd_b, input logic wr_b,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] rd, input int lat,
                          input logic [31:0] rdata, input logic [3:0] emask,
                          input logic [31:0] ewdata, input logic [31:0] eld);
        ex_valid = 1'b1; ex_mem_read = rd_b; ex_mem_write = wr_b;
        ex_funct3 = f3; ex_addr = addr; ex_store_data = sdata; ex_rd = rd;
        #1 chk({tag, "/stall_accept"}, 32'(mem_stall), 32'd1);
        @(negedge clk);
        clear_ex();
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) @(negedge clk);
            chk({tag, "/dmem_read"}, 32'(dmem_read), 32'(!wr_b));
            chk({tag, "/dmem_write"}, 32'(dmem_write), 32'(wr_b));
            chk({tag, "/dmem_address"}, dmem_address, {addr[31:2], 2'b00});
            chk({tag, "/dmem_wmask"}, 32'(dmem_wmask), 32'(emask));
            if (wr_b) chk({tag, "/dmem_wdata"}, dmem_wdata, ewdata);
            if (k == lat) begin
                dmem_resp  = 1'b1;
                dmem_rdata = rdata;
            end
            #1 chk({tag, "/stall_wait"}, 32'(mem_stall), 32'(k != lat));
        end
        @(negedge clk);
        dmem_resp  = 1'b0;
        dmem_rdata = '0;
        chk({tag, "/wb_valid"}, 32'(wb_valid), 32'd1);
        chk({tag, "/wb_rd"}, 32'(wb_rd), 32'(rd));
        chk({tag, "/wb_load_data"}, wb_load_data, eld);
        chk({tag, "/wb_misaligned"}, 32'(wb_misaligned), 32'd0);
        chk({tag, "/strobes_drop"}, 32'({dmem_read, dmem_write}), 32'd0);
    endtask

    // Non-memory or faulting op: no stall, result at T+1, no memory traffic.
    task automatic simple_op(input string tag, input logic rd_b, input logic wr_b,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [4:0] rd, input logic exp_mis);
        ex_valid = 1'b1; ex_mem_read = rd_b; ex_mem_write = wr_b;
        ex_funct3 = f3; ex_addr = addr; ex_store_data = 32'h5555_AAAA; ex_rd = rd;
        #1 chk({tag, "/stall"}, 32'(mem_stall), 32'd0);
        @(negedge clk);
        clear_ex();
        chk({tag, "/wb_valid"}, 32'(wb_valid), 32'd1);
        chk({tag, "/wb_misaligned"}, 32'(wb_misaligned), 32'(exp_mis));
        chk({tag, "/wb_rd"}, 32'(wb_rd), 32'(rd));
        if (!exp_mis) chk({tag, "/wb_load_data"}, wb_load_data, 32'd0);
        chk({tag, "/no_strobe"}, 32'({dmem_read, dmem_write}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clear_ex();
        ex_funct3 = '0; ex_addr = '0; ex_store_data = '0; ex_rd = '0;
        dmem_rdata = '0; dmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset/dmem_read", 32'(dmem_read), 32'd0);
        chk("reset/dmem_write", 32'(dmem_write), 32'd0);
        chk("reset/dmem_address", dmem_address, 32'd0);
        chk("reset/wb_valid", 32'(wb_valid), 32'd0);
        chk("reset/wb_load_data", wb_load_data, 32'd0);
        chk("reset/wb_misaligned", 32'(wb_misaligned), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        mem_op("lw", 1, 0, 3'b010, 32'h0000_1000, 32'h0, 5'd5, 2, 32'hDEAD_BEEF,
               4'b0000, 32'h0, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("lw/wb_pulse_end", 32'(wb_valid), 32'd0);
        chk("lw/wb_data_hold", wb_load_data, 32'hDEAD_BEEF);

        mem_op("lb", 1, 0, 3'b000, 32'h0000_1003, 32'h0, 5'd6, 1, 32'h80FF_FFFF,
               4'b0000, 32'h0, 32'hFFFF_FF80);
        mem_op("lbu", 1, 0, 3'b100, 32'h0000_1003, 32'h0, 5'd7, 0, 32'h80FF_FFFF,
               4'b0000, 32'h0, 32'h0000_0080);
        mem_op("sh", 0, 1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 5'd8, 1, 32'hFFFF_FFFF,
               4'b1100, 32'hABCD_ABCD, 32'h0);

        simple_op("lw_mis", 1, 0, 3'b010, 32'h0000_1001, 5'd9, 1);
        simple_op("sh_mis", 0, 1, 3'b001, 32'h0000_2003, 5'd10, 1);
        simple_op("ld_f3_011", 1, 0, 3'b011, 32'h0000_0000, 5'd11, 1);
        simple_op("st_f3_100", 0, 1, 3'b100, 32'h0000_0000, 5'd18, 1);
        simple_op("nonmem", 0, 0, 3'b000, 32'h0000_0000, 5'd12, 0);

        mem_op("sb_b2b", 0, 1, 3'b000, 32'h0000_3001, 32'h1234_5678, 5'd13, 0, 32'h0,
               4'b0010, 32'h7878_7878, 32'h0);
        mem_op("lhu_b2b", 1, 0, 3'b101, 32'h0000_3002, 32'h0, 5'd14, 0, 32'hBEEF_1234,
               4'b0000, 32'h0, 32'h0000_BEEF);
        mem_op("lh", 1, 0, 3'b001, 32'h0000_3002, 32'h0, 5'd15, 1, 32'hBEEF_1234,
               4'b0000, 32'h0, 32'hFFFF_BEEF);
        mem_op("sw_both", 1, 1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 5'd16, 0, 32'h0,
               4'b1111, 32'hCAFE_F00D, 32'h0);

        // Stray response while idle.
        @(negedge clk);
        dmem_resp = 1'b1;
        dmem_rdata = 32'h1111_1111;
        #1 chk("idle_resp/stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        dmem_resp = 1'b0;
        chk("idle_resp/wb_valid", 32'(wb_valid), 32'd0);
        chk("idle_resp/dmem_read", 32'(dmem_read), 32'd0);

        // Reset during an access, resp coincident with reset and one after it.
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'b010;
        ex_addr = 32'h0000_5000; ex_rd = 5'd17;
        @(negedge clk);
        clear_ex();
        chk("rst_mid/dmem_read", 32'(dmem_read), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        dmem_resp = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid/dmem_read_low", 32'(dmem_read), 32'd0);
        chk("rst_mid/dmem_address", dmem_address, 32'd0);
        chk("rst_mid/wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_mid/wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_mid/wb_load_data", wb_load_data, 32'd0);
        #1 chk("rst_mid/stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        dmem_resp = 1'b0;
        chk("rst_mid/late_resp_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_mid/late_resp_data", wb_load_data, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
